// File: rtl/mult_accum_if.sv
// Handshake bundle between the product source, the mult_accum reduction
// stage and the result consumer.
//
// Handshake semantics, both channels: a beat transfers on a rising clk edge
// where valid && ready are both high. The side that drives valid keeps it and
// its payload stable until that transfer happens. Neither ready depends
// combinationally on the other side's valid.
interface mult_accum_if #(
  parameter int ACC_W = 12,
  parameter int CNT_W = 4
);
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_product;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  // Source/consumer side.
  modport master (
    output start, len, in_valid, in_product, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  // Accumulator side.
  modport slave (
    input  start, len, in_valid, in_product, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/mult_accum.sv
// mult_accum: sums a programmed number of 8-bit products into an ACC_W-bit
// result and presents it on a valid/ready output.
// Optional feature macro: MULT_ACCUM_SATURATE_EN -- when defined, the
// accumulator clamps at 2^ACC_W-1 on carry out instead of wrapping.
// The overflow flag is sticky for the job in both builds.
module mult_accum #(
  parameter int ACC_W = 12,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  mult_accum_if.slave bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q;
  state_t           state_d;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] len_q;
  logic             ovf_q;

  logic             acc_en;
  logic             last_term;
  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic [ACC_W-1:0] acc_nxt;

  // A product is taken only in ACC; ready is a pure state decode.
  assign acc_en    = (state_q == S_ACC) && bus.in_valid;
  assign last_term = (cnt_q == (len_q - CNT_ONE));

  // One extra bit on the adder gives the carry that feeds the flag.
  assign sum_ext = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, bus.in_product};
  assign carry   = sum_ext[ACC_W];

`ifdef MULT_ACCUM_SATURATE_EN
  assign acc_nxt = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
  assign acc_nxt = sum_ext[ACC_W-1:0];
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!n_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode; start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = (bus.len == '0) ? S_HOLD : S_ACC;
      S_ACC:  if (acc_en && last_term) state_d = S_HOLD;
      S_HOLD: if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs come from registers only; no path from in_valid or out_ready.
  always_comb begin
    bus.in_ready  = (state_q == S_ACC);
    bus.out_valid = (state_q == S_HOLD);
    bus.out_sum   = acc_q;
    bus.out_ovf   = ovf_q;
    dbg_state     = state_q;
  end

  // Datapath: clear on an accepted start, accumulate on each transfer.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            len_q <= bus.len;
          end
        end
        S_ACC: begin
          if (acc_en) begin
            acc_q <= acc_nxt;
            cnt_q <= cnt_q + CNT_ONE;
            if (carry) ovf_q <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_accum.sv
// Directed bench for mult_accum: a 12-bit instance for the functional
// vectors and a 10-bit instance for the overflow vector.
module tb_mult_accum;

  logic clk;
  logic n_rst;
  logic [1:0] dbg_state;
  logic [1:0] dbg_state2;

  mult_accum_if #(.ACC_W(12), .CNT_W(4)) bus ();
  mult_accum_if #(.ACC_W(10), .CNT_W(4)) bus2 ();

  mult_accum #(.ACC_W(12), .CNT_W(4)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  mult_accum #(.ACC_W(10), .CNT_W(4)) dut2 (
    .clk       (clk),
    .n_rst     (n_rst),
    .bus       (bus2),
    .dbg_state (dbg_state2)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  logic [11:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle past it; inputs set afterwards are sampled
  // at the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [3:0] l);
    bus.start = 1'b1;
    bus.len   = l;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send(input logic [7:0] p, input int gap);
    int w;
    w = 0;
    while (!bus.in_ready && w < 20) begin
      tick();
      w++;
    end
    check("send_in_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid   = 1'b1;
    bus.in_product = p;
    tick();
    bus.in_valid   = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic expect_result(input string tag, input logic exp_ovf);
    logic [11:0] e;
    for (int i = 0; i < 20 && !bus.out_valid; i++) tick();
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    e = exp_q.pop_front();
    check({tag, "_sum"}, {20'd0, bus.out_sum}, {20'd0, e});
    check({tag, "_ovf"}, {31'd0, bus.out_ovf}, {31'd0, exp_ovf});
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_idle_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_idle_state"}, {30'd0, dbg_state}, 32'd0);
  endtask

  initial begin
    n_rst          = 1'b0;
    bus.start      = 1'b0;
    bus.len        = '0;
    bus.in_valid   = 1'b0;
    bus.in_product = '0;
    bus.out_ready  = 1'b0;
    bus2.start      = 1'b0;
    bus2.len        = '0;
    bus2.in_valid   = 1'b0;
    bus2.in_product = '0;
    bus2.out_ready  = 1'b0;
    tick();
    tick();
    n_rst = 1'b1;

    // Reset state
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_sum",   {20'd0, bus.out_sum},   32'd0);
    check("rst_out_ovf",   {31'd0, bus.out_ovf},   32'd0);
    check("rst_state",     {30'd0, dbg_state},     32'd0);
    tick();
    check("idle_in_ready", {31'd0, bus.in_ready},  32'd0);

    // Basic sum: 15 + 225 + 100 = 340, back to back
    exp_q.push_back(12'd340);
    start_job(4'd3);
    check("basic_acc_ready", {31'd0, bus.in_ready}, 32'd1);
    send(8'd15, 0);
    send(8'd225, 0);
    send(8'd100, 0);
    check("basic_valid_next", {31'd0, bus.out_valid}, 32'd1);
    check("basic_ready_drop", {31'd0, bus.in_ready},  32'd0);
    expect_result("basic", 1'b0);

    // Zero length: straight to HOLD, nothing accepted even with in_valid up
    exp_q.push_back(12'd0);
    bus.in_valid   = 1'b1;
    bus.in_product = 8'd55;
    start_job(4'd0);
    check("zero_valid", {31'd0, bus.out_valid}, 32'd1);
    check("zero_ready", {31'd0, bus.in_ready},  32'd0);
    tick();
    check("zero_hold_ready", {31'd0, bus.in_ready}, 32'd0);
    expect_result("zero", 1'b0);
    bus.in_valid = 1'b0;

    // Bubbles: 1 + 2 + 3 + 4 = 10 with 2-cycle gaps, then backpressure
    exp_q.push_back(12'd10);
    start_job(4'd4);
    send(8'd1, 2);
    send(8'd2, 2);
    send(8'd3, 2);
    send(8'd4, 0);
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_sum",   {20'd0, bus.out_sum},   32'd10);
      check("bp_ready", {31'd0, bus.in_ready},  32'd0);
      tick();
    end
    expect_result("bubble", 1'b0);

    // Ignored start during ACC and HOLD: 10 + 20 = 30
    exp_q.push_back(12'd30);
    start_job(4'd2);
    send(8'd10, 0);
    bus.start = 1'b1;
    bus.len   = 4'd7;
    tick();
    bus.start = 1'b0;
    send(8'd20, 0);
    check("ign_hold", {30'd0, dbg_state}, 32'd2);
    bus.start = 1'b1;
    tick();
    check("ign_hold_stay", {30'd0, dbg_state}, 32'd2);
    check("ign_hold_sum",  {20'd0, bus.out_sum}, 32'd30);
    // start stays high across the output handshake and must be ignored
    expect_result("ignore", 1'b0);
    bus.start = 1'b0;
    check("ign_idle_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    check("ign_still_idle", {30'd0, dbg_state}, 32'd0);

    // Reset in the middle of a job
    start_job(4'd4);
    send(8'd5, 0);
    send(8'd6, 0);
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    check("mid_rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
    check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_out_sum",   {20'd0, bus.out_sum},   32'd0);
    check("mid_rst_out_ovf",   {31'd0, bus.out_ovf},   32'd0);
    exp_q.push_back(12'd9);
    start_job(4'd1);
    send(8'd9, 0);
    expect_result("post_rst", 1'b0);

    // Overflow on the 10-bit instance: 5 x 225 = 1125
    bus2.start = 1'b1;
    bus2.len   = 4'd5;
    tick();
    bus2.start      = 1'b0;
    bus2.in_valid   = 1'b1;
    bus2.in_product = 8'd225;
    repeat (5) tick();
    bus2.in_valid = 1'b0;
    check("ovf_valid", {31'd0, bus2.out_valid}, 32'd1);
`ifdef MULT_ACCUM_SATURATE_EN
    check("ovf_sum", {22'd0, bus2.out_sum}, 32'd1023);
`else
    check("ovf_sum", {22'd0, bus2.out_sum}, 32'd101);
`endif
    check("ovf_flag", {31'd0, bus2.out_ovf}, 32'd1);
    tick();
    check("ovf_flag_hold", {31'd0, bus2.out_ovf}, 32'd1);
    bus2.out_ready = 1'b1;
    tick();
    bus2.out_ready = 1'b0;
    check("ovf_idle", {30'd0, dbg_state2}, 32'd0);

    // A new start clears the sticky flag
    bus2.start = 1'b1;
    bus2.len   = 4'd1;
    tick();
    bus2.start      = 1'b0;
    bus2.in_valid   = 1'b1;
    bus2.in_product = 8'd3;
    tick();
    bus2.in_valid = 1'b0;
    check("ovf_clr_valid", {31'd0, bus2.out_valid}, 32'd1);
    check("ovf_clr_sum",   {22'd0, bus2.out_sum},   32'd3);
    check("ovf_clr_flag",  {31'd0, bus2.out_ovf},   32'd0);
    bus2.out_ready = 1'b1;
    tick();
    bus2.out_ready = 1'b0;

    // Final report
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
